writeback_queue: RTL and testbench

Buffered writer for the register unit's single write port (`RUWr`/`Rd`/`DataWr`). It accepts write requests from two producers over valid/ready handshakes: source A is the single-cycle ALU path, and source B is a long-latency unit such as the multiplier or load return. Requests go into an in-order FIFO and are drained one per cycle into a registered write stage. The block also reports, per read-register query, whether a write to that register is still pending in the queue, so the issue logic can stall.

---
 rtl/writeback_queue.sv | 113 +++++++++++
 tb/tb_writeback_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// In-order writeback buffer for the register unit's single write port.
// Two producers (A has priority), one pop per cycle into a registered write stage.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_rd,
    input  logic [XLEN-1:0]            a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_rd,
    input  logic [XLEN-1:0]            b_data,
    input  logic                       drain_en,
    input  logic [4:0]                 q_rs1,
    input  logic [4:0]                 q_rs2,
    output logic                       busy_rs1,
    output logic                       busy_rs2,
    output logic                       RUWr,
    output logic [4:0]                 Rd,
    output logic [XLEN-1:0]            DataWr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic            full;
    logic            a_fire;
    logic            b_fire;
    logic [4:0]      enq_rd;
    logic [XLEN-1:0] enq_data;
    logic            enq;
    logic            pop;
    logic [PW-1:0]   offset;

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign full     = (count == CW'(DEPTH));
    assign a_ready  = !full;
    assign b_ready  = !full && !a_valid;
    assign a_fire   = a_valid && a_ready;
    assign b_fire   = b_valid && b_ready;
    assign enq_rd   = a_fire ? a_rd   : b_rd;
    assign enq_data = a_fire ? a_data : b_data;
    assign enq      = (a_fire || b_fire) && (enq_rd != 5'd0);
    assign pop      = drain_en && (count != '0);

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[tail]   <= enq_rd;
            data_mem[tail] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RUWr   <= 1'b0;
            Rd     <= '0;
            DataWr <= '0;
        end else if (pop) begin
            RUWr   <= 1'b1;
            Rd     <= rd_mem[head];
            DataWr <= data_mem[head];
        end else begin
            RUWr   <= 1'b0;
        end
    end

    // An entry is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if ({1'b0, offset} < count) begin
                if (rd_mem[i] == q_rs1) busy_rs1 = 1'b1;
                if (rd_mem[i] == q_rs2) busy_rs2 = 1'b1;
            end
        end
        if (q_rs1 == 5'd0) busy_rs1 = 1'b0;
        if (q_rs2 == 5'd0) busy_rs2 = 1'b0;
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed test-plan steps then random traffic,
// checked against a queue-based model of pending writes.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk;
    logic            rst_n;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [4:0]      a_rd, b_rd, q_rs1, q_rs2, Rd;
    logic [XLEN-1:0] a_data, b_data, DataWr;
    logic            drain_en, busy_rs1, busy_rs2, RUWr;
    logic [2:0]      count;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mq[$];
    logic            exp_wr;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
    bit              acc_a, acc_b;
    int              checks = 0;
    int              errors = 0;

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .drain_en(drain_en), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .RUWr(RUWr), .Rd(Rd), .DataWr(DataWr), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelBusy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                                 input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bd,
                                 input logic dr, input logic [4:0] q1, input logic [4:0] q2);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        drain_en = dr; q_rs1 = q1; q_rs2 = q2;
    endtask

    // Pop reads the pre-edge queue before any push, so a fresh entry never retires at once.
    task automatic modelEdge();
        entry_t e;
        bit room;
        room  = (mq.size() < DEPTH);
        acc_a = a_valid && room;
        acc_b = b_valid && room && !a_valid;
        if (drain_en && mq.size() > 0) begin
            e = mq.pop_front();
            exp_wr = 1'b1; exp_rd = e.rd; exp_data = e.data;
        end else begin
            exp_wr = 1'b0;
        end
        if (acc_a && a_rd != 5'd0) mq.push_back('{a_rd, a_data});
        else if (acc_b && b_rd != 5'd0) mq.push_back('{b_rd, b_data});
    endtask

    task automatic step();
        #1;
        checkOutput("a_ready", 64'(a_ready), 64'(mq.size() != DEPTH));
        checkOutput("b_ready", 64'(b_ready), 64'((mq.size() != DEPTH) && !a_valid));
        checkOutput("busy_rs1", 64'(busy_rs1), 64'(modelBusy(q_rs1)));
        checkOutput("busy_rs2", 64'(busy_rs2), 64'(modelBusy(q_rs2)));
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("RUWr", 64'(RUWr), 64'(exp_wr));
        checkOutput("Rd", 64'(Rd), 64'(exp_rd));
        checkOutput("DataWr", 64'(DataWr), 64'(exp_data));
        checkOutput("count", 64'(count), 64'(mq.size()));
    endtask

    task automatic idle(input logic dr, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, dr, 0, 0);
            step();
        end
    endtask

    initial begin
        int nb;
        int guard;
        exp_wr = 1'b0; exp_rd = '0; exp_data = '0;
        rst_n = 1'b0;
        applyStimulus(1, 5, 32'h1, 0, 0, 0, 1, 5, 0);
        #1;
        checkOutput("reset_a_ready", 64'(a_ready), 64'd1);
        checkOutput("reset_b_ready_a_hi", 64'(b_ready), 64'd0);
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_RUWr", 64'(RUWr), 64'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0);
        #1;
        checkOutput("reset_b_ready_a_lo", 64'(b_ready), 64'd1);
        rst_n = 1'b1;

        $display("[TB] single write");
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 0);
        step();
        checkOutput("single_busy_after_e0", 64'(busy_rs1), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0);
        step();
        checkOutput("single_data", 64'(DataWr), 64'hDEADBEEF);
        idle(1, 1);

        $display("[TB] priority");
        applyStimulus(1, 3, 32'hA3, 1, 4, 32'hB4, 1, 3, 4);
        step();
        applyStimulus(0, 0, 0, 1, 4, 32'hB4, 1, 3, 4);
        step();
        checkOutput("prio_first_rd", 64'(Rd), 64'd3);
        idle(1, 1);
        checkOutput("prio_second_rd", 64'(Rd), 64'd4);
        idle(1, 1);

        $display("[TB] fill and wrap");
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(0, 0, 0, 1, 5'(r), 32'h100 + r, 0, 5'(r), 0);
            step();
        end
        checkOutput("fill_count", 64'(count), 64'd4);
        nb = 5;
        guard = 0;
        while (nb <= 8 && guard < 40) begin
            applyStimulus(0, 0, 0, 1, 5'(nb), 32'h100 + nb, 1, 5'(nb), 1);
            step();
            if (acc_b) nb++;
            guard++;
        end
        checkOutput("fill_b_traffic_done", 64'(nb), 64'd9);
        idle(1, 6);

        $display("[TB] x0 drop");
        applyStimulus(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0);
        step();
        idle(1, 2);

        $display("[TB] same-register ordering");
        applyStimulus(1, 7, 32'h11, 0, 0, 0, 0, 7, 0);
        step();
        applyStimulus(1, 7, 32'h22, 0, 0, 0, 0, 7, 0);
        step();
        idle(0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0);
        step();
        checkOutput("same_rd_first", 64'(DataWr), 64'h11);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0);
        step();
        checkOutput("same_rd_second", 64'(DataWr), 64'h22);
        idle(1, 1);

        $display("[TB] reset mid-operation");
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(1, 5'(r), 32'h200 + r, 0, 0, 0, 0, 2, 3);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 3);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_RUWr", 64'(RUWr), 64'd0);
        checkOutput("midrst_Rd", 64'(Rd), 64'd0);
        checkOutput("midrst_DataWr", 64'(DataWr), 64'd0);
        checkOutput("midrst_count", 64'(count), 64'd0);
        checkOutput("midrst_busy1", 64'(busy_rs1), 64'd0);
        checkOutput("midrst_busy2", 64'(busy_rs2), 64'd0);
        checkOutput("midrst_a_ready", 64'(a_ready), 64'd1);
        mq.delete();
        exp_wr = 1'b0; exp_rd = '0; exp_data = '0;
        #2;
        rst_n = 1'b1;
        idle(1, 3);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
        idle(1, DEPTH + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
